// File: rtl/native_port_arbiter_pkg.sv
// Shared types and native-port defaults for the two-requester LiteDRAM native port arbiter.
package native_port_arbiter_pkg;

  localparam int unsigned NATIVE_ADDR_W = 25;
  localparam int unsigned NATIVE_DATA_W = 256;
  localparam int unsigned NATIVE_MASK_W = NATIVE_DATA_W / 8;
  localparam int unsigned RD_DEPTH_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_WDATA = 2'd2
  } arb_state_t;

endpackage

// File: rtl/native_rd_id_fifo.sv
// DEPTH x 1-bit FIFO recording which requester issued each outstanding read.
module native_rd_id_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     user_clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     push_id,
  input  logic                     pop,
  output logic                     head_id,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DEPTH-1:0] mem;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head_id = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge user_clk) begin
    if (reset) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_id;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/native_port_arbiter.sv
// Round-robin sharing of one LiteDRAM native user port between two requesters,
// with read-return steering through a small issue-order ID FIFO.
module native_port_arbiter
  import native_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = NATIVE_ADDR_W,
  parameter int unsigned DATA_W   = NATIVE_DATA_W,
  parameter int unsigned MASK_W   = NATIVE_MASK_W,
  parameter int unsigned RD_DEPTH = RD_DEPTH_DEF
) (
  input  logic                       user_clk,
  input  logic                       reset,

  input  logic                       c0_cmd_valid,
  output logic                       c0_cmd_ready,
  input  logic                       c0_cmd_we,
  input  logic [ADDR_W-1:0]          c0_cmd_addr,
  input  logic                       c0_wdata_valid,
  output logic                       c0_wdata_ready,
  input  logic [MASK_W-1:0]          c0_wdata_we,
  input  logic [DATA_W-1:0]          c0_wdata_data,
  output logic                       c0_rdata_valid,
  input  logic                       c0_rdata_ready,
  output logic [DATA_W-1:0]          c0_rdata_data,

  input  logic                       c1_cmd_valid,
  output logic                       c1_cmd_ready,
  input  logic                       c1_cmd_we,
  input  logic [ADDR_W-1:0]          c1_cmd_addr,
  input  logic                       c1_wdata_valid,
  output logic                       c1_wdata_ready,
  input  logic [MASK_W-1:0]          c1_wdata_we,
  input  logic [DATA_W-1:0]          c1_wdata_data,
  output logic                       c1_rdata_valid,
  input  logic                       c1_rdata_ready,
  output logic [DATA_W-1:0]          c1_rdata_data,

  output logic                       m_cmd_valid,
  input  logic                       m_cmd_ready,
  output logic                       m_cmd_we,
  output logic [ADDR_W-1:0]          m_cmd_addr,
  output logic                       m_wdata_valid,
  input  logic                       m_wdata_ready,
  output logic [MASK_W-1:0]          m_wdata_we,
  output logic [DATA_W-1:0]          m_wdata_data,
  input  logic                       m_rdata_valid,
  output logic                       m_rdata_ready,
  input  logic [DATA_W-1:0]          m_rdata_data,

  output logic                       grant_id,
  output logic [$clog2(RD_DEPTH):0]  rd_outstanding,
  output logic                       rd_underflow
);

  arb_state_t state;
  arb_state_t state_nx;
  logic       prio;
  logic       prio_nx;
  logic       grant_q;
  logic       grant_nx;

  logic       fifo_empty;
  logic       fifo_full;
  logic       head_id;
  logic       rd_push;
  logic       rd_pop;

  logic       elig0;
  logic       elig1;
  logic       g_cmd_valid;
  logic       g_wdata_valid;
  logic       cmd_phase;
  logic       wdata_phase;
  logic       cmd_hs;
  logic       wdata_hs;

  assign elig0 = c0_cmd_valid & (c0_cmd_we | ~fifo_full);
  assign elig1 = c1_cmd_valid & (c1_cmd_we | ~fifo_full);

  assign g_cmd_valid   = grant_q ? c1_cmd_valid   : c0_cmd_valid;
  assign g_wdata_valid = grant_q ? c1_wdata_valid : c0_wdata_valid;
  assign m_cmd_we      = grant_q ? c1_cmd_we      : c0_cmd_we;
  assign m_cmd_addr    = grant_q ? c1_cmd_addr    : c0_cmd_addr;
  assign m_wdata_we    = grant_q ? c1_wdata_we    : c0_wdata_we;
  assign m_wdata_data  = grant_q ? c1_wdata_data  : c0_wdata_data;

  // Write data may ride along with its command, so the wdata path is open in CMD for writes.
  assign cmd_phase   = (state == ST_CMD);
  assign wdata_phase = (cmd_phase & m_cmd_we) | (state == ST_WDATA);

  assign m_cmd_valid    = cmd_phase & g_cmd_valid;
  assign m_wdata_valid  = wdata_phase & g_wdata_valid;
  assign cmd_hs         = m_cmd_valid & m_cmd_ready;
  assign wdata_hs       = m_wdata_valid & m_wdata_ready;

  assign c0_cmd_ready   = cmd_phase & ~grant_q & m_cmd_ready;
  assign c1_cmd_ready   = cmd_phase &  grant_q & m_cmd_ready;
  assign c0_wdata_ready = wdata_phase & ~grant_q & m_wdata_ready;
  assign c1_wdata_ready = wdata_phase &  grant_q & m_wdata_ready;

  assign grant_id = grant_q;

  always_comb begin
    state_nx = state;
    prio_nx  = prio;
    grant_nx = grant_q;
    rd_push  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (elig0 | elig1) begin
          grant_nx = (elig0 & elig1) ? prio : elig1;
          state_nx = ST_CMD;
        end
      end
      ST_CMD: begin
        if (cmd_hs) begin
          if (!m_cmd_we) begin
            rd_push  = 1'b1;
            prio_nx  = ~grant_q;
            state_nx = ST_IDLE;
          end else if (wdata_hs) begin
            prio_nx  = ~grant_q;
            state_nx = ST_IDLE;
          end else begin
            state_nx = ST_WDATA;
          end
        end
      end
      ST_WDATA: begin
        if (wdata_hs) begin
          prio_nx  = ~grant_q;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      prio    <= 1'b0;
      grant_q <= 1'b0;
    end else begin
      state   <= state_nx;
      prio    <= prio_nx;
      grant_q <= grant_nx;
    end
  end

  // Read return follows issue order; nothing is accepted while no read is outstanding.
  assign m_rdata_ready  = ~fifo_empty & (head_id ? c1_rdata_ready : c0_rdata_ready);
  assign c0_rdata_valid = ~fifo_empty & ~head_id & m_rdata_valid;
  assign c1_rdata_valid = ~fifo_empty &  head_id & m_rdata_valid;
  assign c0_rdata_data  = m_rdata_data;
  assign c1_rdata_data  = m_rdata_data;
  assign rd_pop         = m_rdata_valid & m_rdata_ready;

  always_ff @(posedge user_clk) begin
    if (reset) begin
      rd_underflow <= 1'b0;
    end else if (fifo_empty & m_rdata_valid) begin
      rd_underflow <= 1'b1;
    end
  end

  native_rd_id_fifo #(
    .DEPTH (RD_DEPTH)
  ) u_rd_id_fifo (
    .user_clk (user_clk),
    .reset    (reset),
    .push     (rd_push),
    .push_id  (grant_q),
    .pop      (rd_pop),
    .head_id  (head_id),
    .count    (rd_outstanding),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

endmodule

// File: tb/tb_native_port_arbiter.sv
// Self-checking bench for native_port_arbiter: arbitration table, directed corner
// sequences and randomized traffic against a transaction-level scoreboard.
module tb_native_port_arbiter;

  localparam int unsigned AW    = 25;
  localparam int unsigned DW    = 256;
  localparam int unsigned MW    = 32;
  localparam int unsigned DEPTH = 2;

  logic user_clk;
  logic reset;

  logic c0_cmd_valid, c0_cmd_ready, c0_cmd_we;
  logic [AW-1:0] c0_cmd_addr;
  logic c0_wdata_valid, c0_wdata_ready;
  logic [MW-1:0] c0_wdata_we;
  logic [DW-1:0] c0_wdata_data;
  logic c0_rdata_valid, c0_rdata_ready;
  logic [DW-1:0] c0_rdata_data;

  logic c1_cmd_valid, c1_cmd_ready, c1_cmd_we;
  logic [AW-1:0] c1_cmd_addr;
  logic c1_wdata_valid, c1_wdata_ready;
  logic [MW-1:0] c1_wdata_we;
  logic [DW-1:0] c1_wdata_data;
  logic c1_rdata_valid, c1_rdata_ready;
  logic [DW-1:0] c1_rdata_data;

  logic m_cmd_valid, m_cmd_ready, m_cmd_we;
  logic [AW-1:0] m_cmd_addr;
  logic m_wdata_valid, m_wdata_ready;
  logic [MW-1:0] m_wdata_we;
  logic [DW-1:0] m_wdata_data;
  logic m_rdata_valid, m_rdata_ready;
  logic [DW-1:0] m_rdata_data;

  logic grant_id;
  logic [$clog2(DEPTH):0] rd_outstanding;
  logic rd_underflow;

  int checks = 0;
  int errors = 0;

  native_port_arbiter #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .MASK_W   (MW),
    .RD_DEPTH (DEPTH)
  ) dut (
    .user_clk       (user_clk),
    .reset          (reset),
    .c0_cmd_valid   (c0_cmd_valid),
    .c0_cmd_ready   (c0_cmd_ready),
    .c0_cmd_we      (c0_cmd_we),
    .c0_cmd_addr    (c0_cmd_addr),
    .c0_wdata_valid (c0_wdata_valid),
    .c0_wdata_ready (c0_wdata_ready),
    .c0_wdata_we    (c0_wdata_we),
    .c0_wdata_data  (c0_wdata_data),
    .c0_rdata_valid (c0_rdata_valid),
    .c0_rdata_ready (c0_rdata_ready),
    .c0_rdata_data  (c0_rdata_data),
    .c1_cmd_valid   (c1_cmd_valid),
    .c1_cmd_ready   (c1_cmd_ready),
    .c1_cmd_we      (c1_cmd_we),
    .c1_cmd_addr    (c1_cmd_addr),
    .c1_wdata_valid (c1_wdata_valid),
    .c1_wdata_ready (c1_wdata_ready),
    .c1_wdata_we    (c1_wdata_we),
    .c1_wdata_data  (c1_wdata_data),
    .c1_rdata_valid (c1_rdata_valid),
    .c1_rdata_ready (c1_rdata_ready),
    .c1_rdata_data  (c1_rdata_data),
    .m_cmd_valid    (m_cmd_valid),
    .m_cmd_ready    (m_cmd_ready),
    .m_cmd_we       (m_cmd_we),
    .m_cmd_addr     (m_cmd_addr),
    .m_wdata_valid  (m_wdata_valid),
    .m_wdata_ready  (m_wdata_ready),
    .m_wdata_we     (m_wdata_we),
    .m_wdata_data   (m_wdata_data),
    .m_rdata_valid  (m_rdata_valid),
    .m_rdata_ready  (m_rdata_ready),
    .m_rdata_data   (m_rdata_data),
    .grant_id       (grant_id),
    .rd_outstanding (rd_outstanding),
    .rd_underflow   (rd_underflow)
  );

  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  task automatic mid();
    @(negedge user_clk);
  endtask

  task automatic idle_inputs();
    c0_cmd_valid = 0; c0_cmd_we = 0; c0_cmd_addr = '0;
    c0_wdata_valid = 0; c0_wdata_we = '0; c0_wdata_data = '0; c0_rdata_ready = 0;
    c1_cmd_valid = 0; c1_cmd_we = 0; c1_cmd_addr = '0;
    c1_wdata_valid = 0; c1_wdata_we = '0; c1_wdata_data = '0; c1_rdata_ready = 0;
    m_cmd_ready = 0; m_wdata_ready = 0; m_rdata_valid = 0; m_rdata_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int i = 0; i < int'(DW / 32); i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Arbitration table applied from the reset state (priority pointer 0, empty FIFO).
  typedef struct {
    logic          v0, we0, v1, we1;
    logic          exp_mv, exp_gid, exp_we;
    logic [AW-1:0] exp_addr;
  } vec_t;
  vec_t vecs[7];

  // Randomized-phase requester, memory-side and scoreboard state.
  logic          rq_cv[2], rq_we[2], rq_wv[2], rq_wpend[2];
  logic [AW-1:0] rq_addr[2];
  logic [DW-1:0] rq_data[2];
  logic [MW-1:0] rq_mask[2];
  int            q_rd[$];
  int            q_w[$];
  logic          mrv;
  logic [DW-1:0] mrd;

  task automatic apply_req();
    c0_cmd_valid = rq_cv[0]; c0_cmd_we = rq_we[0]; c0_cmd_addr = rq_addr[0];
    c0_wdata_valid = rq_wv[0]; c0_wdata_we = rq_mask[0]; c0_wdata_data = rq_data[0];
    c1_cmd_valid = rq_cv[1]; c1_cmd_we = rq_we[1]; c1_cmd_addr = rq_addr[1];
    c1_wdata_valid = rq_wv[1]; c1_wdata_we = rq_mask[1]; c1_wdata_data = rq_data[1];
    m_rdata_valid = mrv; m_rdata_data = mrd;
  endtask

  initial begin
    int gq[$];
    int rq[$];
    int n0;
    logic got;

    vecs[0] = '{0, 0, 0, 0, 0, 0, 0, '0};
    vecs[1] = '{1, 0, 0, 0, 1, 0, 0, 25'h0A0};
    vecs[2] = '{0, 0, 1, 0, 1, 1, 0, 25'h1B1};
    vecs[3] = '{1, 1, 0, 0, 1, 0, 1, 25'h0A0};
    vecs[4] = '{0, 0, 1, 1, 1, 1, 1, 25'h1B1};
    vecs[5] = '{1, 0, 1, 0, 1, 0, 0, 25'h0A0};
    vecs[6] = '{1, 0, 1, 1, 1, 0, 0, 25'h0A0};

    // Reset state
    do_reset();
    mid();
    chk("rst_m_cmd_valid", m_cmd_valid, 0);
    chk("rst_m_wdata_valid", m_wdata_valid, 0);
    chk("rst_m_rdata_ready", m_rdata_ready, 0);
    chk("rst_c_readies", {c0_cmd_ready, c1_cmd_ready, c0_wdata_ready, c1_wdata_ready}, 0);
    chk("rst_c_rdata_valid", {c0_rdata_valid, c1_rdata_valid}, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_rd_outstanding", rd_outstanding, 0);
    chk("rst_rd_underflow", rd_underflow, 0);

    // Arbitration table
    for (int i = 0; i < 7; i++) begin
      do_reset();
      c0_cmd_valid = vecs[i].v0; c0_cmd_we = vecs[i].we0; c0_cmd_addr = 25'h0A0;
      c1_cmd_valid = vecs[i].v1; c1_cmd_we = vecs[i].we1; c1_cmd_addr = 25'h1B1;
      mid();
      chk($sformatf("tbl%0d_idle_latency", i), m_cmd_valid, 0);
      tick();
      mid();
      chk($sformatf("tbl%0d_m_cmd_valid", i), m_cmd_valid, vecs[i].exp_mv);
      chk($sformatf("tbl%0d_grant_id", i), grant_id, vecs[i].exp_gid);
      if (vecs[i].exp_mv) begin
        chk($sformatf("tbl%0d_m_cmd_addr", i), m_cmd_addr, vecs[i].exp_addr);
        chk($sformatf("tbl%0d_m_cmd_we", i), m_cmd_we, vecs[i].exp_we);
      end
    end

    // c0 read at 0x400, routed return
    do_reset();
    c0_cmd_valid = 1; c0_cmd_we = 0; c0_cmd_addr = 25'h400; m_cmd_ready = 1;
    mid();
    chk("rd_latency_idle", m_cmd_valid, 0);
    tick();
    mid();
    chk("rd_m_cmd_valid", m_cmd_valid, 1);
    chk("rd_m_cmd_addr", m_cmd_addr, 25'h400);
    chk("rd_m_cmd_we", m_cmd_we, 0);
    chk("rd_c0_cmd_ready", c0_cmd_ready, 1);
    tick();
    c0_cmd_valid = 0;
    m_rdata_valid = 1; m_rdata_data = {32{8'hA5}};
    c0_rdata_ready = 1; c1_rdata_ready = 1;
    mid();
    chk("rd_outstanding_1", rd_outstanding, 1);
    chk("rd_c0_rdata_valid", c0_rdata_valid, 1);
    chk("rd_c1_rdata_valid", c1_rdata_valid, 0);
    chk("rd_m_rdata_ready", m_rdata_ready, 1);
    chk("rd_c0_rdata_data", c0_rdata_data, {32{8'hA5}});
    tick();
    m_rdata_valid = 0;
    mid();
    chk("rd_outstanding_0", rd_outstanding, 0);

    // c1 single-cycle write, then pointer back at c0
    c1_cmd_valid = 1; c1_cmd_we = 1; c1_cmd_addr = 25'h123;
    c1_wdata_valid = 1; c1_wdata_we = '1; c1_wdata_data = {8{32'hC0FFEE01}};
    m_wdata_ready = 1;
    tick();
    mid();
    chk("wr1_m_cmd_valid", m_cmd_valid, 1);
    chk("wr1_grant_id", grant_id, 1);
    chk("wr1_m_wdata_valid", m_wdata_valid, 1);
    chk("wr1_c1_readies", {c1_cmd_ready, c1_wdata_ready}, 2'b11);
    chk("wr1_m_wdata_we", m_wdata_we, {MW{1'b1}});
    chk("wr1_m_wdata_data", m_wdata_data, {8{32'hC0FFEE01}});
    tick();
    c1_cmd_valid = 0; c1_wdata_valid = 0;
    mid();
    chk("wr1_back_idle", {m_cmd_valid, m_wdata_valid}, 0);
    c0_cmd_valid = 1; c0_cmd_we = 0; c1_cmd_valid = 1; c1_cmd_we = 0; m_cmd_ready = 0;
    tick();
    mid();
    chk("wr1_prio_back_to_c0", grant_id, 0);

    // c0 write with wdata 3 cycles after the cmd handshake; c1 must wait
    do_reset();
    c0_cmd_valid = 1; c0_cmd_we = 1; c0_cmd_addr = 25'h0C0;
    c0_wdata_we = 32'h0000FFFF; c0_wdata_data = {4{64'h0123456789ABCDEF}};
    m_cmd_ready = 1; m_wdata_ready = 1;
    tick();
    mid();
    chk("wd_c0_cmd_ready", c0_cmd_ready, 1);
    chk("wd_no_early_wdata", m_wdata_valid, 0);
    tick();
    c0_cmd_valid = 0;
    c1_cmd_valid = 1; c1_cmd_we = 0; c1_cmd_addr = 25'h1C1;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk($sformatf("wd_wait%0d_m_cmd_valid", i), m_cmd_valid, 0);
      chk($sformatf("wd_wait%0d_c1_cmd_ready", i), c1_cmd_ready, 0);
      chk($sformatf("wd_wait%0d_grant_id", i), grant_id, 0);
      tick();
    end
    c0_wdata_valid = 1;
    mid();
    chk("wd_m_wdata_valid", m_wdata_valid, 1);
    chk("wd_c0_wdata_ready", c0_wdata_ready, 1);
    chk("wd_m_wdata_we", m_wdata_we, 32'h0000FFFF);
    chk("wd_m_wdata_data", m_wdata_data, {4{64'h0123456789ABCDEF}});
    tick();
    c0_wdata_valid = 0;
    mid();
    chk("wd_idle_after", m_cmd_valid, 0);
    tick();
    mid();
    chk("wd_c1_granted", grant_id, 1);
    chk("wd_c1_cmd_ready", c1_cmd_ready, 1);

    // Both requesters reading continuously: grants and returns alternate
    do_reset();
    c0_cmd_valid = 1; c0_cmd_we = 0; c0_cmd_addr = 25'h010;
    c1_cmd_valid = 1; c1_cmd_we = 0; c1_cmd_addr = 25'h020;
    c0_rdata_ready = 1; c1_rdata_ready = 1; m_cmd_ready = 1;
    m_rdata_data = {16{16'h5A5A}};
    gq.delete(); rq.delete();
    for (int i = 0; i < 60 && (gq.size() < 4 || rq.size() < 4); i++) begin
      mid();
      if (c0_cmd_ready) gq.push_back(0);
      if (c1_cmd_ready) gq.push_back(1);
      if (c0_rdata_valid && m_rdata_ready) rq.push_back(0);
      if (c1_rdata_valid && m_rdata_ready) rq.push_back(1);
      tick();
      m_rdata_valid = (gq.size() > rq.size());
    end
    chk("alt_grant_count_ok", gq.size() >= 4, 1);
    chk("alt_return_count_ok", rq.size() >= 4, 1);
    for (int j = 0; j < 4; j++) begin
      if (gq.size() > j) chk($sformatf("alt_grant%0d", j), gq[j], j % 2);
      if (rq.size() > j) chk($sformatf("alt_return%0d", j), rq[j], j % 2);
    end

    // Full FIFO: reads stall, writes pass, one pop re-enables reads
    do_reset();
    c0_cmd_valid = 1; c0_cmd_we = 0; c0_cmd_addr = 25'h030; m_cmd_ready = 1;
    n0 = 0;
    for (int i = 0; i < 10; i++) begin
      mid();
      if (c0_cmd_ready) n0++;
      tick();
    end
    mid();
    chk("full_reads_granted", n0, 2);
    chk("full_rd_outstanding", rd_outstanding, 2);
    chk("full_read_stalled", m_cmd_valid, 0);
    c1_cmd_valid = 1; c1_cmd_we = 1; c1_cmd_addr = 25'h040;
    c1_wdata_valid = 1; c1_wdata_we = '1; c1_wdata_data = {8{32'hFEEDBEEF}};
    m_wdata_ready = 1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      mid();
      if (c1_cmd_ready && c1_wdata_ready) got = 1;
      tick();
    end
    chk("full_write_granted", got, 1);
    c1_cmd_valid = 0; c1_wdata_valid = 0;
    m_rdata_valid = 1; m_rdata_data = {8{32'h11223344}}; c0_rdata_ready = 1;
    mid();
    chk("full_still_stalled", m_cmd_valid, 0);
    chk("full_pop_c0_valid", c0_rdata_valid, 1);
    tick();
    m_rdata_valid = 0;
    mid();
    chk("full_no_pop_bypass", m_cmd_valid, 0);
    chk("full_rd_outstanding_1", rd_outstanding, 1);
    tick();
    mid();
    chk("full_read_after_pop", c0_cmd_ready, 1);

    // Randomized traffic against the scoreboard
    do_reset();
    for (int k = 0; k < 2; k++) begin
      rq_cv[k] = 0; rq_we[k] = 0; rq_wv[k] = 0; rq_wpend[k] = 0;
      rq_addr[k] = '0; rq_data[k] = '0; rq_mask[k] = '0;
    end
    q_rd.delete(); q_w.delete();
    mrv = 0; mrd = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int   cid;
      int   wown;
      logic whs;
      logic w_same;
      logic rhs;
      logic exp_mrr;
      logic exp_v0;
      logic exp_v1;
      mid();
      exp_mrr = 0; exp_v0 = 0; exp_v1 = 0;
      if (q_rd.size() > 0) begin
        exp_mrr = (q_rd[0] == 0) ? c0_rdata_ready : c1_rdata_ready;
        exp_v0  = (q_rd[0] == 0) && m_rdata_valid;
        exp_v1  = (q_rd[0] == 1) && m_rdata_valid;
      end
      chk("rnd_rd_outstanding", rd_outstanding, q_rd.size());
      chk("rnd_m_rdata_ready", m_rdata_ready, exp_mrr);
      chk("rnd_rdata_valid", {c1_rdata_valid, c0_rdata_valid}, {exp_v1, exp_v0});
      chk("rnd_rdata_bcast", {c1_rdata_data == m_rdata_data, c0_rdata_data == m_rdata_data}, 2'b11);
      chk("rnd_cmd_ready_hs", c0_cmd_ready | c1_cmd_ready, m_cmd_valid & m_cmd_ready);
      chk("rnd_cmd_ready_excl", c0_cmd_ready & c1_cmd_ready, 0);
      chk("rnd_wready_gate", (c0_wdata_ready | c1_wdata_ready) & ~m_wdata_ready, 0);
      chk("rnd_underflow", rd_underflow, 0);
      cid = c0_cmd_ready ? 0 : (c1_cmd_ready ? 1 : -1);
      if (cid >= 0) begin
        chk("rnd_cmd_owner_valid", rq_cv[cid], 1);
        chk("rnd_cmd_addr", m_cmd_addr, rq_addr[cid]);
        chk("rnd_cmd_we", m_cmd_we, rq_we[cid]);
      end
      whs  = m_wdata_valid & m_wdata_ready;
      wown = -1;
      if (whs) begin
        if (q_w.size() > 0) wown = q_w[0];
        else if (cid >= 0 && rq_we[cid]) wown = cid;
        if (wown < 0) begin
          checks++;
          errors++;
          $display("FAIL rnd_wdata_owner: actual=wdata_handshake_without_write required=none");
        end else begin
          chk("rnd_wdata_data", m_wdata_data, rq_data[wown]);
          chk("rnd_wdata_we", m_wdata_we, rq_mask[wown]);
          chk("rnd_wdata_readies", {c1_wdata_ready, c0_wdata_ready}, (wown == 1) ? 2'b10 : 2'b01);
        end
      end
      rhs    = m_rdata_valid & m_rdata_ready;
      w_same = whs && (q_w.size() == 0);
      if (rhs) begin
        if (q_rd.size() > 0) void'(q_rd.pop_front());
        mrv = 0;
      end
      if (cid >= 0) begin
        rq_cv[cid] = 0;
        if (!rq_we[cid]) q_rd.push_back(cid);
        else if (!w_same) q_w.push_back(cid);
      end
      if (wown >= 0) begin
        rq_wpend[wown] = 0;
        rq_wv[wown] = 0;
        if (!w_same && q_w.size() > 0) void'(q_w.pop_front());
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        if (!rq_cv[k] && !rq_wpend[k] && ($urandom % 3 == 0)) begin
          rq_cv[k]    = 1;
          rq_we[k]    = $urandom % 2;
          rq_addr[k]  = AW'($urandom);
          rq_data[k]  = rand_data();
          rq_mask[k]  = MW'($urandom);
          rq_wpend[k] = rq_we[k];
          rq_wv[k]    = rq_we[k] && ($urandom % 2 == 0);
        end else if (rq_wpend[k] && !rq_wv[k] && ($urandom % 2 == 0)) begin
          rq_wv[k] = 1;
        end
      end
      c0_rdata_ready = ($urandom % 4 != 0);
      c1_rdata_ready = ($urandom % 4 != 0);
      m_cmd_ready    = ($urandom % 3 != 0);
      // The native port takes write data only with or after its command.
      m_wdata_ready  = (q_w.size() > 0) ? ($urandom % 2 == 0) : (m_cmd_ready && ($urandom % 2 == 0));
      if (!mrv && q_rd.size() > 0 && ($urandom % 2 == 0)) begin
        mrv = 1;
        mrd = rand_data();
      end
      apply_req();
    end

    // Read data with nothing outstanding
    do_reset();
    m_rdata_valid = 1; m_rdata_data = {8{32'hDEADBEEF}};
    c0_rdata_ready = 1; c1_rdata_ready = 1;
    mid();
    chk("uf_m_rdata_ready", m_rdata_ready, 0);
    chk("uf_no_route", {c0_rdata_valid, c1_rdata_valid}, 0);
    tick();
    m_rdata_valid = 0;
    mid();
    chk("uf_flag_set", rd_underflow, 1);
    tick();
    tick();
    mid();
    chk("uf_flag_sticky", rd_underflow, 1);
    chk("uf_outstanding", rd_outstanding, 0);
    do_reset();
    mid();
    chk("uf_cleared_by_reset", rd_underflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
